trail_renderer: RTL and testbench
=================================

Name: trail_renderer

Overview:
- Parametrised motion-trail overlay for the saber/pointer display path.
- Keeps a history of DEPTH tracked (x,y) positions, sampled on new-frame pulses.
- Each history entry is rendered as a square sprite that shrinks and darkens with age.
- Emits a pipelined 24-bit pixel colour and a hit flag per (hcount,vcount) for the downstream pixel mixer.

Parameters:
DEPTH, 5, number of history entries (2..16); entry 0 is newest.
BASE_SIZE, 15, side length in pixels of entry 0 square.
SIZE_STEP, 3, side decrement per entry age; side_i = max(1, BASE_SIZE - i*SIZE_STEP).
BASE_COLOR, 24'hFF_FF_FF, colour of entry 0.
COLOR_STEP, 8'h22, per-channel decrement per age; chan_i = max(0, base_chan - i*COLOR_STEP), computed at elaboration.
SAMPLE_DIV, 1, history shifts once every SAMPLE_DIV nf_in pulses (1..255).

Ports:
clk_in  input  1  pixel clock
rst_n_in  input  1  asynchronous active-low reset
nf_in  input  1  new-frame pulse, one cycle
clear_in  input  1  synchronous trail clear
valid_in  input  1  tracker has a valid position this frame
x_in  input  12  tracked x, top-left of newest square
y_in  input  11  tracked y, top-left of newest square
hcount_in  input  11  current pixel column
vcount_in  input  10  current pixel row
color_out  output  24  trail colour, {R,G,B}; 0 when no hit
hit_out  output  1  any valid entry covers the pixel

Behaviour:
- Reset: all entries have valid=0 and x=y=0; sample counter=0; pipeline registers=0; color_out=0; hit_out=0.
- Sample counter advances on each nf_in pulse.
  - When counter==SAMPLE_DIV-1 on an nf_in pulse: counter returns to 0 and the history shifts.
  - Otherwise: counter increments and the history holds.
- History shift: entry[i] <= entry[i-1] for i>=1; entry[0] <= {valid_in, x_in, y_in}.
  - An invalid sample still shifts, so the trail drains while tracking is lost.
- clear_in: all valid bits <= 0 and counter <= 0.
  - clear_in wins over a simultaneous nf_in; no shift happens that cycle.
- History changes only on nf_in cycles, so geometry is stable across an active frame.
- Hit test for entry i:
  - valid_i && {1'b0,hcount} >= x_i && hcount < x_i+side_i && vcount >= y_i && vcount < y_i+side_i.
  - Sums use 13-bit (x) and 12-bit (y) widths, so there is no wrap-around.
  - Squares extending past the screen are clipped naturally.
- Pipeline latency is 2 cycles from hcount_in/vcount_in to color_out/hit_out.
  - Stage 1 registers the DEPTH-bit hit vector.
  - Stage 2 registers the resolved colour and hit flag.
- Resolution: the lowest-index (newest) hit entry wins; its colour goes to color_out. No hit gives color_out=0 and hit_out=0.
- The pipeline runs every cycle with no stall or handshake. The caller delays sync/blank by 2 cycles to match.
- Async reset mid-frame clears history and pipeline immediately. Output resumes 2 cycles after deassertion, with an empty trail.

Optional Feature:
- Macro: TRAIL_BLEND_EN.
- Defined: color_out is the per-channel saturating sum (clamped at 8'hFF) of the colours of all hit entries. Overlapping trail segments brighten. Latency is still 2; summation tree sits in stage 2.
- Undefined: newest-wins priority as above.
- hit_out is identical in both modes.

Test Plan:
- Reset, then sweep the full frame -> color_out=0 and hit_out=0 everywhere.
- valid_in=1, x=100, y=50, one nf_in (SAMPLE_DIV=1); probe (100,50) -> 24'hFFFFFF after 2 cycles. Probe (115,50) -> 0 (side 15 exclusive).
- Five nf_in pulses, x advancing by 40 each frame -> five squares of sides 15,12,9,6,3. Colours are FF,DD,BB,99,77 per channel; the oldest square is at the first x.
- Two entries overlap at one pixel -> newest colour without the macro. With TRAIL_BLEND_EN: FF+DD saturates to FF per channel, BB+99 gives FF.
- SAMPLE_DIV=3, six nf_in pulses -> exactly 2 shifts. clear_in together with nf_in -> all invalid, no shift, counter=0.
- x_in=4090, y_in=2040 -> no wrap hit at hcount=0 or vcount=0. Assert rst_n_in mid-line -> outputs 0 on the same edge.

Source files
------------

// File: rtl/trail_renderer.sv
// Motion-trail overlay: DEPTH-entry position history rendered as shrinking, darkening squares.
// Optional macro TRAIL_BLEND_EN switches newest-wins colour priority to saturating per-channel blend.
module trail_renderer #(
    parameter int          DEPTH      = 5,
    parameter int          BASE_SIZE  = 15,
    parameter int          SIZE_STEP  = 3,
    parameter logic [23:0] BASE_COLOR = 24'hFF_FF_FF,
    parameter logic [7:0]  COLOR_STEP = 8'h22,
    parameter int          SAMPLE_DIV = 1
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        nf_in,
    input  logic        clear_in,
    input  logic        valid_in,
    input  logic [11:0] x_in,
    input  logic [10:0] y_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    output logic [23:0] color_out,
    output logic        hit_out
);

    localparam logic [7:0] LAST_COUNT = 8'(SAMPLE_DIV - 1);

    function automatic logic [12:0] side_of(input int idx);
        int s;
        s = BASE_SIZE - idx * SIZE_STEP;
        if (s < 1) s = 1;
        return s[12:0];
    endfunction

    function automatic logic [23:0] color_of(input int idx);
        logic [23:0] c;
        int          ch;
        c = '0;
        for (int k = 0; k < 3; k++) begin
            ch = int'(BASE_COLOR[k*8 +: 8]) - idx * int'(COLOR_STEP);
            if (ch < 0) ch = 0;
            c[k*8 +: 8] = ch[7:0];
        end
        return c;
    endfunction

    logic [7:0]       count_reg;
    logic [DEPTH-1:0] valid_reg;
    logic [11:0]      x_reg [DEPTH];
    logic [10:0]      y_reg [DEPTH];

    logic [DEPTH-1:0] hit_vec;
    logic [DEPTH-1:0] hit_s1_reg;
    logic [23:0]      entry_color [DEPTH];
    logic [23:0]      color_next;
    logic             hit_next;
    logic [23:0]      color_reg;
    logic             hit_reg;

    // History only moves on frame boundaries, keeping geometry stable during active video.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count_reg <= '0;
            valid_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                x_reg[i] <= '0;
                y_reg[i] <= '0;
            end
        end else if (clear_in) begin
            count_reg <= '0;
            valid_reg <= '0;
        end else if (nf_in) begin
            if (count_reg == LAST_COUNT) begin
                count_reg    <= '0;
                valid_reg[0] <= valid_in;
                x_reg[0]     <= x_in;
                y_reg[0]     <= y_in;
                for (int i = 1; i < DEPTH; i++) begin
                    valid_reg[i] <= valid_reg[i-1];
                    x_reg[i]     <= x_reg[i-1];
                    y_reg[i]     <= y_reg[i-1];
                end
            end else begin
                count_reg <= count_reg + 8'd1;
            end
        end
    end

    // Bounds are widened by one bit so squares near the screen edge clip instead of wrapping.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic [12:0] SIDE = side_of(gi);
            logic [12:0] x_end;
            logic [11:0] y_end;
            assign x_end = {1'b0, x_reg[gi]} + SIDE;
            assign y_end = {1'b0, y_reg[gi]} + SIDE[11:0];
            assign entry_color[gi] = color_of(gi);
            assign hit_vec[gi] = valid_reg[gi]
                              && ({1'b0, hcount_in} >= x_reg[gi])
                              && ({2'b00, hcount_in} < x_end)
                              && ({1'b0, vcount_in} >= y_reg[gi])
                              && ({2'b00, vcount_in} < y_end);
        end
    endgenerate

`ifdef TRAIL_BLEND_EN
    logic [12:0] chan_sum;

    always_comb begin
        color_next = '0;
        chan_sum   = '0;
        for (int k = 0; k < 3; k++) begin
            chan_sum = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (hit_s1_reg[i]) chan_sum = chan_sum + {5'd0, entry_color[i][k*8 +: 8]};
            end
            color_next[k*8 +: 8] = (chan_sum > 13'd255) ? 8'hFF : chan_sum[7:0];
        end
    end
`else
    // Scan oldest to newest so the lowest-index hit is the one left standing.
    always_comb begin
        color_next = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hit_s1_reg[i]) color_next = entry_color[i];
        end
    end
`endif

    assign hit_next = |hit_s1_reg;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hit_s1_reg <= '0;
            color_reg  <= '0;
            hit_reg    <= 1'b0;
        end else begin
            hit_s1_reg <= hit_vec;
            color_reg  <= color_next;
            hit_reg    <= hit_next;
        end
    end

    assign color_out = color_reg;
    assign hit_out   = hit_reg;

endmodule

// File: tb/tb_trail_renderer.sv
// Bench for trail_renderer: two instances (SAMPLE_DIV 1 and 3) checked against constants and a frame-level model.
module tb_trail_renderer;

    localparam int DEPTH = 5;

    logic        clk = 1'b0;
    logic        rst_n, nf, clr, valid;
    logic [11:0] x;
    logic [10:0] y;
    logic [10:0] h;
    logic [9:0]  v;
    logic [23:0] color_a, color_b;
    logic        hit_a, hit_b;

    int tests = 0;
    int fails = 0;

    int mv [2][DEPTH];
    int mx [2][DEPTH];
    int my [2][DEPTH];
    int mcnt [2];
    int mdiv [2] = '{1, 3};

    int qh[$];
    int qv[$];

    typedef struct {
        int          hh;
        int          vv;
        logic [24:0] exp;
    } vec_t;
    vec_t tbl [14];

    always #5 clk = ~clk;

    trail_renderer dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .nf_in(nf), .clear_in(clr), .valid_in(valid),
        .x_in(x), .y_in(y), .hcount_in(h), .vcount_in(v),
        .color_out(color_a), .hit_out(hit_a)
    );

    trail_renderer #(.SAMPLE_DIV(3)) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .nf_in(nf), .clear_in(clr), .valid_in(valid),
        .x_in(x), .y_in(y), .hcount_in(h), .vcount_in(v),
        .color_out(color_b), .hit_out(hit_b)
    );

    // Reference: each trail square drawn from its age, newest first.
    function automatic logic [24:0] model(input int k, input int hh, input int vv);
        int sum;
        int side;
        int chan;
        bit any;
        logic [7:0] first;
        any = 0;
        sum = 0;
        first = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            side = 15 - 3 * i;
            if (side < 1) side = 1;
            chan = 255 - 34 * i;
            if (chan < 0) chan = 0;
            if (mv[k][i] != 0 && hh >= mx[k][i] && hh < mx[k][i] + side &&
                vv >= my[k][i] && vv < my[k][i] + side) begin
                if (!any) first = chan[7:0];
                any = 1;
                sum += chan;
            end
        end
        if (!any) return 25'h0;
`ifdef TRAIL_BLEND_EN
        if (sum > 255) sum = 255;
        return {1'b1, {3{sum[7:0]}}};
`else
        return {1'b1, {3{first}}};
`endif
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0;
            for (int i = 0; i < DEPTH; i++) begin
                mv[k][i] = 0; mx[k][i] = 0; my[k][i] = 0;
            end
        end
    endtask

    task automatic model_frame(input bit c, input bit n, input bit vi, input int xi, input int yi);
        for (int k = 0; k < 2; k++) begin
            if (c) begin
                mcnt[k] = 0;
                for (int i = 0; i < DEPTH; i++) mv[k][i] = 0;
            end else if (n) begin
                mcnt[k]++;
                if (mcnt[k] == mdiv[k]) begin
                    mcnt[k] = 0;
                    for (int i = DEPTH - 1; i > 0; i--) begin
                        mv[k][i] = mv[k][i-1]; mx[k][i] = mx[k][i-1]; my[k][i] = my[k][i-1];
                    end
                    mv[k][0] = vi; mx[k][0] = xi; my[k][0] = yi;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got hit=%0b color=%06h, want hit=%0b color=%06h",
                     name, act[24], act[23:0], exp[24], exp[23:0]);
        end
    endtask

    // All tasks start and finish 1 time unit after a rising edge.
    task automatic pulse(input bit vi, input int xi, input int yi, input bit c, input bit n);
        valid = vi; x = 12'(xi); y = 11'(yi); nf = n; clr = c;
        @(posedge clk); #1;
        nf = 1'b0; clr = 1'b0;
        model_frame(c, n, vi, xi, yi);
    endtask

    task automatic probe(input string name, input int hh, input int vv,
                         input bit use_a, input logic [24:0] exp_a,
                         input bit use_b, input logic [24:0] exp_b);
        h = 11'(hh); v = 10'(vv);
        @(posedge clk); @(posedge clk); #1;
        if (use_a) check({name, "_a"}, {hit_a, color_a}, exp_a);
        if (use_b) check({name, "_b"}, {hit_b, color_b}, exp_b);
        check({name, "_model_a"}, {hit_a, color_a}, model(0, hh, vv));
        check({name, "_model_b"}, {hit_b, color_b}, model(1, hh, vv));
        $display("[TB] probe %s (%0d,%0d): a=%0b/%06h b=%0b/%06h", name, hh, vv,
                 hit_a, color_a, hit_b, color_b);
    endtask

    // Back-to-back coordinates, one per cycle, each compared two cycles later.
    task automatic stream(input string name);
        int n;
        n = qh.size();
        for (int j = 0; j <= n; j++) begin
            if (j < n) begin
                h = 11'(qh[j]); v = 10'(qv[j]);
            end
            @(posedge clk); #1;
            if (j >= 1) begin
                check({name, "_a"}, {hit_a, color_a}, model(0, qh[j-1], qv[j-1]));
                check({name, "_b"}, {hit_b, color_b}, model(1, qh[j-1], qv[j-1]));
            end
        end
        $display("[TB] stream %s: %0d pixels", name, n);
        qh.delete(); qv.delete();
    endtask

    initial begin
        logic [24:0] ov_exp;

        tbl[0]  = '{260,  50, 25'h1FFFFFF};
        tbl[1]  = '{274,  64, 25'h1FFFFFF};
        tbl[2]  = '{275,  50, 25'h0000000};
        tbl[3]  = '{220,  50, 25'h1DDDDDD};
        tbl[4]  = '{231,  61, 25'h1DDDDDD};
        tbl[5]  = '{232,  50, 25'h0000000};
        tbl[6]  = '{180,  50, 25'h1BBBBBB};
        tbl[7]  = '{188,  58, 25'h1BBBBBB};
        tbl[8]  = '{140,  55, 25'h1999999};
        tbl[9]  = '{146,  50, 25'h0000000};
        tbl[10] = '{100,  50, 25'h1777777};
        tbl[11] = '{102,  52, 25'h1777777};
        tbl[12] = '{103,  50, 25'h0000000};
        tbl[13] = '{100,  53, 25'h0000000};

        rst_n = 1'b0; nf = 1'b0; clr = 1'b0; valid = 1'b0;
        x = '0; y = '0; h = '0; v = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_a", {hit_a, color_a}, 25'h0);
        check("reset_b", {hit_b, color_b}, 25'h0);
        rst_n = 1'b1;

        for (int vv = 0; vv < 1024; vv += 31)
            for (int hh = 0; hh < 2048; hh += 41) begin
                qh.push_back(hh); qv.push_back(vv);
            end
        stream("empty_sweep");

        pulse(1, 100, 50, 0, 1);
        probe("single_in",   100, 50, 1, 25'h1FFFFFF, 0, 25'h0);
        probe("single_xend", 115, 50, 1, 25'h0,       0, 25'h0);
        probe("single_last", 114, 64, 1, 25'h1FFFFFF, 0, 25'h0);
        probe("single_yend", 100, 65, 1, 25'h0,       0, 25'h0);

        for (int k = 0; k < 5; k++) pulse(1, 100 + 40 * k, 50, 0, 1);
        for (int t = 0; t < 14; t++)
            probe($sformatf("five_%0d", t), tbl[t].hh, tbl[t].vv, 1, tbl[t].exp, 0, 25'h0);

        pulse(0, 0, 0, 1, 0);
        pulse(1, 500, 50, 0, 1);
        pulse(1, 502, 50, 0, 1);
        pulse(1, 900, 50, 0, 1);
        pulse(1, 950, 50, 0, 1);
`ifdef TRAIL_BLEND_EN
        ov_exp = 25'h1FFFFFF;
`else
        ov_exp = 25'h1BBBBBB;
`endif
        probe("overlap",     503, 51, 1, ov_exp,      0, 25'h0);
        probe("overlap_old", 501, 51, 1, 25'h1999999, 0, 25'h0);

        pulse(0, 0, 0, 1, 0);
        pulse(1, 4090, 2040, 0, 1);
        probe("wrap_00",    0,    0, 1, 25'h0, 0, 25'h0);
        probe("wrap_05",    0,    5, 1, 25'h0, 0, 25'h0);
        probe("wrap_30",    3,    0, 1, 25'h0, 0, 25'h0);
        probe("wrap_max", 2047, 1023, 1, 25'h0, 0, 25'h0);

        pulse(0, 0, 0, 1, 0);
        for (int k = 0; k < 6; k++) pulse(1, 1200 + 30 * k, 300, 0, 1);
        probe("div3_e0",   1350, 300, 1, 25'h1FFFFFF, 1, 25'h1FFFFFF);
        probe("div3_e1",   1260, 300, 1, 25'h1999999, 1, 25'h1DDDDDD);
        probe("div3_skip", 1290, 300, 1, 25'h1BBBBBB, 1, 25'h0);
        probe("div3_old",  1200, 300, 1, 25'h0,       1, 25'h0);

        pulse(1, 600, 600, 0, 1);
        pulse(1, 700, 700, 1, 1);
        probe("clrnf_new", 700, 700, 1, 25'h0, 1, 25'h0);
        probe("clrnf_old", 1350, 300, 1, 25'h0, 1, 25'h0);
        pulse(1, 800, 700, 0, 1);
        pulse(1, 800, 700, 0, 1);
        probe("cnt_hold", 800, 700, 1, 25'h1FFFFFF, 1, 25'h0);
        pulse(1, 850, 700, 0, 1);
        probe("cnt_shift", 850, 700, 1, 25'h1FFFFFF, 1, 25'h1FFFFFF);

        for (int r = 0; r < 20; r++) begin
            if ($urandom_range(15) == 0) pulse(0, 0, 0, 1, $urandom_range(1));
            for (int p = 0; p < int'($urandom_range(3, 1)); p++)
                pulse($urandom_range(3) != 0, $urandom_range(400), $urandom_range(300), 0, 1);
            for (int j = 0; j < 40; j++) begin
                qh.push_back($urandom_range(420)); qv.push_back($urandom_range(320));
            end
            stream($sformatf("rand_%0d", r));
        end

        pulse(0, 0, 0, 1, 0);
        pulse(1, 260, 50, 0, 1);
        h = 11'd260; v = 10'd50;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_a", {hit_a, color_a}, 25'h1FFFFFF);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_a", {hit_a, color_a}, 25'h0);
        check("async_rst_b", {hit_b, color_b}, 25'h0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        probe("post_rst", 260, 50, 1, 25'h0, 1, 25'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
